// File: rtl/rom_burst_arbiter_if.sv
// Requester-side bundle of the ROM burst arbiter: two burst request channels
// plus the shared read-data return path.
interface rom_burst_arbiter_if #(
  parameter int AW    = 16,
  parameter int DW    = 8,
  parameter int LEN_W = 8
);
  logic             req0;
  logic             req1;
  logic [AW-1:0]    addr0;
  logic [AW-1:0]    addr1;
  logic [LEN_W-1:0] len0;
  logic [LEN_W-1:0] len1;
  logic             ack0;
  logic             ack1;
  logic             err0;
  logic             err1;
  logic             rvalid0;
  logic             rvalid1;
  logic             done0;
  logic             done1;
  logic [DW-1:0]    rdata;

  modport slave (
    input  req0, req1, addr0, addr1, len0, len1,
    output ack0, ack1, err0, err1, rvalid0, rvalid1, done0, done1, rdata
  );

  modport master (
    output req0, req1, addr0, addr1, len0, len1,
    input  ack0, ack1, err0, err1, rvalid0, rvalid1, done0, done1, rdata
  );
endinterface

// File: rtl/rom_burst_arbiter.sv
// Round-robin burst arbiter sharing one registered-read block ROM between two
// requesters; sequences ROM addresses and steers the returned words to the owner.
module rom_burst_arbiter #(
  parameter int AW        = 16,
  parameter int DW        = 8,
  parameter int ROM_DEPTH = 61440,
  parameter int ROM_LAT   = 1,
  parameter int LEN_W     = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  rom_burst_arbiter_if.slave    bus,
  output logic [AW-1:0]         rom_addra,
  input  logic [DW-1:0]         rom_douta,
  output logic                  busy
);

  localparam int DCW = $clog2(ROM_LAT + 1);
  localparam logic [AW:0]   DEPTH_X   = (AW+1)'(ROM_DEPTH);
  localparam logic [AW-1:0] LAST_ADDR = AW'(ROM_DEPTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

  state_t           state_q, state_d;
  logic             owner_q, owner_d;
  logic             rr_q, rr_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W:0]   cnt_q, cnt_d;
  logic [DCW-1:0]   dcnt_q, dcnt_d;
  logic             ack_q, ack_d;
  logic             err_q, err_d;
  logic [ROM_LAT:0] pv_q, pv_d;
  logic [ROM_LAT:0] pl_q, pl_d;
  logic [ROM_LAT:0] po_q, po_d;
  logic [DW-1:0]    rdata_q, rdata_d;

  logic             grant_sel;
  logic [AW-1:0]    start_addr;
  logic [LEN_W-1:0] start_len;
  logic             start_bad;
  logic             issuing;
  logic             last_word;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      owner_q <= 1'b0;
      rr_q    <= 1'b0;
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      dcnt_q  <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      pv_q    <= '0;
      pl_q    <= '0;
      po_q    <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      dcnt_q  <= dcnt_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      pv_q    <= pv_d;
      pl_q    <= pl_d;
      po_q    <= po_d;
      rdata_q <= rdata_d;
    end
  end

  // rr_q names the requester that wins when both ask in the same cycle.
  always_comb begin
    grant_sel  = (bus.req0 & bus.req1) ? rr_q : bus.req1;
    start_addr = grant_sel ? bus.addr1 : bus.addr0;
    start_len  = grant_sel ? bus.len1 : bus.len0;
    start_bad  = ({1'b0, start_addr} >= DEPTH_X);
    issuing    = (state_q == S_ISSUE);
    last_word  = issuing && (cnt_q == {1'b0, len_q});
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    addr_d  = addr_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    dcnt_d  = dcnt_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.req0 | bus.req1) begin
          state_d = S_ISSUE;
          owner_d = grant_sel;
          rr_d    = ~grant_sel;
          addr_d  = start_bad ? '0 : start_addr;
          len_d   = start_len;
          cnt_d   = '0;
          ack_d   = 1'b1;
          err_d   = start_bad;
        end
      end
      S_ISSUE: begin
        addr_d = (addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1;
        if (last_word) begin
          state_d = S_DRAIN;
          dcnt_d  = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DRAIN: begin
        // Stay until the last issued word has left the valid pipeline.
        if (dcnt_q == DCW'(ROM_LAT)) begin
          state_d = S_IDLE;
        end else begin
          dcnt_d = dcnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Valid/last/owner travel with each issued address so steering never
    // depends on owner_q, which may be overwritten by the next grant.
    pv_d    = {pv_q[ROM_LAT-1:0], issuing};
    pl_d    = {pl_q[ROM_LAT-1:0], last_word};
    po_d    = {po_q[ROM_LAT-1:0], owner_q};
    rdata_d = pv_q[ROM_LAT-1] ? rom_douta : rdata_q;
  end

  always_comb begin
    busy        = (state_q != S_IDLE);
    rom_addra   = issuing ? addr_q : '0;
    bus.ack0    = ack_q & ~owner_q;
    bus.ack1    = ack_q & owner_q;
    bus.err0    = err_q & ~owner_q;
    bus.err1    = err_q & owner_q;
    bus.rvalid0 = pv_q[ROM_LAT] & ~po_q[ROM_LAT];
    bus.rvalid1 = pv_q[ROM_LAT] & po_q[ROM_LAT];
    bus.done0   = pv_q[ROM_LAT] & pl_q[ROM_LAT] & ~po_q[ROM_LAT];
    bus.done1   = pv_q[ROM_LAT] & pl_q[ROM_LAT] & po_q[ROM_LAT];
    bus.rdata   = rdata_q;
  end

endmodule

// File: tb/tb_rom_burst_arbiter.sv
// Bench for rom_burst_arbiter: burst-schedule reference model checked every
// cycle, a vector table, hand-written corner sequences and random traffic.
module tb_rom_burst_arbiter;
  localparam int AW = 16, DW = 8, ROM_DEPTH = 61440, L = 1, LEN_W = 8;
  localparam int MAXC = 16384;

  logic clk = 1'b0;
  logic rst_n;
  logic [AW-1:0] rom_addra;
  logic [DW-1:0] rom_douta;
  logic busy;

  always #5 clk = ~clk;

  rom_burst_arbiter_if #(.AW(AW), .DW(DW), .LEN_W(LEN_W)) bus ();

  rom_burst_arbiter #(.AW(AW), .DW(DW), .ROM_DEPTH(ROM_DEPTH), .ROM_LAT(L), .LEN_W(LEN_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .rom_addra (rom_addra),
    .rom_douta (rom_douta),
    .busy      (busy)
  );

  function automatic logic [7:0] memf(input logic [15:0] a);
    return a[7:0] ^ a[15:8];
  endfunction

  // Behavioural ROM with L-cycle registered read.
  logic [DW-1:0] rom_pipe [L];
  always @(posedge clk) begin
    rom_pipe[0] <= memf(rom_addra);
    for (int k = 1; k < L; k++) rom_pipe[k] <= rom_pipe[k-1];
  end
  assign rom_douta = rom_pipe[L-1];

  typedef struct packed {
    logic ack0, ack1, err0, err1, busy, rv0, rv1, d0, d1;
    logic [15:0] addr;
    logic [7:0]  data;
  } exp_t;

  typedef struct packed {
    logic        sel;
    logic [15:0] addr;
    logic [7:0]  len;
    logic        err;
    logic [15:0] first_addr;
    logic [15:0] last_addr;
    logic [8:0]  words;
    logic [7:0]  first_data;
    logic [7:0]  last_data;
  } vec_t;

  exp_t       ex [MAXC];
  int         cyc;
  int         free_at;
  bit         rr;
  logic [7:0] rdata_exp;
  int         checks;
  int         errors;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp_v);
    end
  endtask

  // Reference model: each grant lays out its whole burst on a per-cycle timeline.
  task automatic model_edge();
    bit g, e;
    logic [15:0] a;
    int n;
    if (rst_n && cyc >= free_at && (bus.req0 || bus.req1)) begin
      g  = (bus.req0 && bus.req1) ? rr : bus.req1;
      rr = ~g;
      a  = g ? bus.addr1 : bus.addr0;
      n  = g ? int'(bus.len1) : int'(bus.len0);
      e  = (int'(a) >= ROM_DEPTH);
      if (e) a = 16'h0000;
      if (g) begin ex[cyc].ack1 = 1'b1; ex[cyc].err1 = e; end
      else   begin ex[cyc].ack0 = 1'b1; ex[cyc].err0 = e; end
      for (int i = 0; i <= n; i++) begin
        if (cyc + i < MAXC) ex[cyc+i].addr = a;
        if (cyc + i + L + 1 < MAXC) begin
          ex[cyc+i+L+1].data = memf(a);
          if (g) begin ex[cyc+i+L+1].rv1 = 1'b1; ex[cyc+i+L+1].d1 = (i == n); end
          else   begin ex[cyc+i+L+1].rv0 = 1'b1; ex[cyc+i+L+1].d0 = (i == n); end
        end
        a = (int'(a) == ROM_DEPTH - 1) ? 16'h0000 : a + 16'h0001;
      end
      for (int k = cyc; k <= cyc + n + L + 1; k++) if (k < MAXC) ex[k].busy = 1'b1;
      free_at = cyc + n + L + 3;
    end
  endtask

  task automatic model_reset();
    for (int i = cyc; i < MAXC; i++) ex[i] = '0;
    free_at   = 0;
    rr        = 1'b0;
    rdata_exp = 8'h00;
  endtask

  task automatic compare();
    exp_t e;
    e = ex[(cyc < MAXC) ? cyc : MAXC-1];
    if (e.rv0 || e.rv1) rdata_exp = e.data;
    chk("ctrl", 32'({bus.ack0, bus.ack1, bus.err0, bus.err1, busy}),
        32'({e.ack0, e.ack1, e.err0, e.err1, e.busy}));
    chk("rom_addra", 32'(rom_addra), 32'(e.addr));
    chk("rvalid_done", 32'({bus.rvalid0, bus.rvalid1, bus.done0, bus.done1}),
        32'({e.rv0, e.rv1, e.d0, e.d1}));
    chk("rdata", 32'(bus.rdata), 32'(rdata_exp));
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    model_edge();
    @(negedge clk);
    compare();
  endtask

  task automatic test_rr();
    int ack_cyc [3] = '{0, 0, 0};
    bit who [3] = '{1'b0, 1'b0, 1'b0};
    int na = 0;
    bus.req0 = 1'b1; bus.addr0 = 16'h0100; bus.len0 = 8'd1;
    bus.req1 = 1'b1; bus.addr1 = 16'h0200; bus.len1 = 8'd1;
    for (int k = 0; k < 60 && na < 3; k++) begin
      step();
      if (bus.ack0 || bus.ack1) begin
        ack_cyc[na] = cyc;
        who[na] = bus.ack1;
        na++;
        if (na == 3) begin bus.req0 = 1'b0; bus.req1 = 1'b0; end
      end
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    chk("rr_grants", 32'(na), 32'd3);
    chk("rr_order", 32'({who[0], who[1], who[2]}), 32'b010);
    chk("rr_gap1", 32'(ack_cyc[1] - ack_cyc[0]), 32'(1 + L + 3));
    chk("rr_gap2", 32'(ack_cyc[2] - ack_cyc[1]), 32'(1 + L + 3));
    repeat (10) step();
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int cnt = 0, oth = 0, done_at = 0;
    logic [7:0]  fd = 8'h00, ld = 8'h00;
    logic [15:0] la;
    if (v.sel) begin bus.req1 = 1'b1; bus.addr1 = v.addr; bus.len1 = v.len; end
    else       begin bus.req0 = 1'b1; bus.addr0 = v.addr; bus.len0 = v.len; end
    step();
    chk($sformatf("vec%0d_ack_err", idx), 32'({bus.ack0, bus.ack1, bus.err0, bus.err1}),
        32'({~v.sel, v.sel, ~v.sel & v.err, v.sel & v.err}));
    chk($sformatf("vec%0d_first_addr", idx), 32'(rom_addra), 32'(v.first_addr));
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    la = rom_addra;
    for (int k = 1; k < int'(v.len) + L + 10 && done_at == 0; k++) begin
      step();
      if (k == int'(v.len)) la = rom_addra;
      if (v.sel ? bus.rvalid1 : bus.rvalid0) begin
        if (cnt == 0) fd = bus.rdata;
        ld = bus.rdata;
        cnt++;
      end
      if (v.sel ? bus.done1 : bus.done0) done_at = cnt;
      if (v.sel ? (bus.rvalid0 | bus.done0) : (bus.rvalid1 | bus.done1)) oth++;
    end
    chk($sformatf("vec%0d_words", idx), 32'(cnt), 32'(v.words));
    chk($sformatf("vec%0d_done_word", idx), 32'(done_at), 32'(v.words));
    chk($sformatf("vec%0d_last_addr", idx), 32'(la), 32'(v.last_addr));
    chk($sformatf("vec%0d_first_data", idx), 32'(fd), 32'(v.first_data));
    chk($sformatf("vec%0d_last_data", idx), 32'(ld), 32'(v.last_data));
    chk($sformatf("vec%0d_other_quiet", idx), 32'(oth), 32'd0);
    repeat (3) step();
  endtask

  task automatic test_reset_mid();
    int nrv = 0, n0 = 0, n1 = 0, done_at = 0;
    bus.req0 = 1'b1; bus.addr0 = 16'h0040; bus.len0 = 8'd7;
    step();
    chk("rst_ack0", 32'(bus.ack0), 32'd1);
    bus.req0 = 1'b0;
    for (int k = 0; k < 20 && nrv < 2; k++) begin
      step();
      if (bus.rvalid0) nrv++;
    end
    step();
    chk("rst_word2_valid", 32'(bus.rvalid0), 32'd1);
    #2;
    rst_n = 1'b0;
    model_reset();
    bus.req1 = 1'b1; bus.addr1 = 16'h0080; bus.len1 = 8'd7;
    #1;
    chk("rst_async_flags", 32'({bus.ack0, bus.ack1, bus.err0, bus.err1, bus.rvalid0,
        bus.rvalid1, bus.done0, bus.done1, busy}), 32'd0);
    chk("rst_async_addr", 32'(rom_addra), 32'd0);
    chk("rst_async_rdata", 32'(bus.rdata), 32'd0);
    repeat (2) begin
      step();
      if (bus.rvalid0 || bus.rvalid1) n0++;
    end
    rst_n = 1'b1;
    step();
    chk("rst_then_ack1", 32'({bus.ack1, bus.ack0}), 32'b10);
    bus.req1 = 1'b0;
    for (int k = 0; k < 40 && done_at == 0; k++) begin
      step();
      if (bus.rvalid0) n0++;
      if (bus.rvalid1) n1++;
      if (bus.done1) done_at = n1;
    end
    chk("rst_no_stale_rvalid0", 32'(n0), 32'd0);
    chk("rst_req1_words", 32'(n1), 32'd8);
    chk("rst_req1_done", 32'(done_at), 32'd8);
    repeat (3) step();
  endtask

  task automatic test_long();
    int cnt = 0, first = -1, last = -1, done_w = 0, extra = 0;
    bus.req0 = 1'b1; bus.addr0 = 16'h0300; bus.len0 = 8'd255;
    step();
    chk("long_ack0", 32'(bus.ack0), 32'd1);
    bus.req0 = 1'b0;
    for (int k = 1; k < 300 && done_w == 0; k++) begin
      step();
      if (bus.ack0) extra++;
      if (bus.rvalid0) begin
        if (first < 0) first = cyc;
        last = cyc;
        cnt++;
      end
      if (bus.done0) done_w = cnt;
      if (k == 10) bus.req0 = 1'b1;
      if (k == 11) bus.req0 = 1'b0;
    end
    repeat (6) begin
      step();
      if (bus.ack0) extra++;
    end
    chk("long_words", 32'(cnt), 32'd256);
    chk("long_no_gap", 32'(last - first + 1), 32'd256);
    chk("long_done_word", 32'(done_w), 32'd256);
    chk("withdrawn_no_ack", 32'(extra), 32'd0);
  endtask

  task automatic start_req(input int r);
    logic [15:0] a;
    logic [7:0]  n;
    case ($urandom_range(0, 3))
      0:       a = 16'($urandom_range(0, ROM_DEPTH - 1));
      1:       a = 16'(ROM_DEPTH - 1 - int'($urandom_range(0, 3)));
      2:       a = 16'(ROM_DEPTH + int'($urandom_range(0, 65535 - ROM_DEPTH)));
      default: a = 16'($urandom);
    endcase
    n = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 40)) : 8'($urandom_range(0, 4));
    if (r == 0) begin bus.addr0 = a; bus.len0 = n; end
    else        begin bus.addr1 = a; bus.len1 = n; end
  endtask

  task automatic test_random();
    bit pend [2] = '{1'b0, 1'b0};
    bit acked;
    for (int t = 0; t < 1500; t++) begin
      step();
      for (int r = 0; r < 2; r++) begin
        acked = (r == 0) ? ex[cyc].ack0 : ex[cyc].ack1;
        if (acked) pend[r] = 1'b0;
        else if (pend[r] && $urandom_range(0, 31) == 0) pend[r] = 1'b0;
        else if (!pend[r] && $urandom_range(0, 5) == 0) begin
          pend[r] = 1'b1;
          start_req(r);
        end
      end
      bus.req0 = pend[0];
      bus.req1 = pend[1];
    end
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    repeat (60) step();
  endtask

  initial begin
    vec_t vecs [6];
    vecs[0] = '{1'b0, 16'h0010, 8'd3, 1'b0, 16'h0010, 16'h0013, 9'd4, 8'h10, 8'h13};
    vecs[1] = '{1'b1, 16'hEFFE, 8'd3, 1'b0, 16'hEFFE, 16'h0001, 9'd4, 8'h11, 8'h01};
    vecs[2] = '{1'b0, 16'hF000, 8'd0, 1'b1, 16'h0000, 16'h0000, 9'd1, 8'h00, 8'h00};
    vecs[3] = '{1'b1, 16'h1234, 8'd0, 1'b0, 16'h1234, 16'h1234, 9'd1, 8'h26, 8'h26};
    vecs[4] = '{1'b0, 16'hEFFF, 8'd1, 1'b0, 16'hEFFF, 16'h0000, 9'd2, 8'h10, 8'h00};
    vecs[5] = '{1'b1, 16'hFFFF, 8'd2, 1'b1, 16'h0000, 16'h0002, 9'd3, 8'h00, 8'h02};

    for (int i = 0; i < MAXC; i++) ex[i] = '0;
    cyc = 0; free_at = 0; rr = 1'b0; rdata_exp = 8'h00;
    checks = 0; errors = 0;
    rst_n = 1'b0;
    bus.req0 = 1'b0; bus.addr0 = '0; bus.len0 = '0;
    bus.req1 = 1'b0; bus.addr1 = '0; bus.len1 = '0;

    repeat (3) step();
    chk("reset_flags", 32'({bus.ack0, bus.ack1, bus.err0, bus.err1, bus.rvalid0,
        bus.rvalid1, bus.done0, bus.done1, busy}), 32'd0);
    rst_n = 1'b1;
    repeat (2) step();

    test_rr();
    for (int v = 0; v < 6; v++) run_vec(v, vecs[v]);
    test_reset_mid();
    test_long();
    test_random();
    chk("cycle_budget", 32'(cyc < MAXC), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
